axis_mvm_sequencer: RTL

AXIS_MVM_SEQUENCER -- requirements
Module: axis_mvm_sequencer

---
 rtl/mvm_seq_pkg.sv | 33 +++
 rtl/mvm_seq_cmd_ram.sv | 41 ++++
 rtl/axis_mvm_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mvm_seq_pkg.sv
// Shared definitions for the MVM command sequencer: op codes, tuser field
// layout and the sequencer state encoding.
package mvm_seq_pkg;

    // tuser field layout: [8:0] address, [10:9] op, [74:11] RF enable mask
    localparam int TU_ADDR_LSB = 0;
    localparam int TU_ADDR_W   = 9;
    localparam int TU_OP_LSB   = 9;
    localparam int TU_OP_W     = 2;
    localparam int TU_MASK_LSB = 11;
    localparam int TU_MASK_W   = 64;
    localparam int TU_W        = TU_MASK_LSB + TU_MASK_W;

    // Command op codes carried in tuser
    localparam logic [1:0] OP_INST = 2'b00;
    localparam logic [1:0] OP_RED  = 2'b01;
    localparam logic [1:0] OP_VEC  = 2'b10;
    localparam logic [1:0] OP_RF   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERR      = 3'd4
    } seq_state_e;

    // Extract the op field from a tuser word
    function automatic logic [TU_OP_W-1:0] tuser_op(input logic [TU_W-1:0] tuser);
        return tuser[TU_OP_LSB +: TU_OP_W];
    endfunction

endpackage

// File: rtl/mvm_seq_cmd_ram.sv
// Command table: single write port, registered read port. A write to the
// address being read in the same cycle is forwarded so the new entry is
// presented immediately. Storage is not reset; only the read register is.
module mvm_seq_cmd_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 599,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Table storage write; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read with write-through forwarding on address match
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= '0;
        end else if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_r <= wr_data;
        end else begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/axis_mvm_sequencer.sv
// AXI-Stream command sequencer for the MVM block. Issues num_cmds entries of
// the command table as single-beat packets, then counts responses until
// exp_rsp have arrived.
// Optional feature: define MVM_SEQ_TIMEOUT_EN to enable a response timeout
// that moves the run to the error state after timeout_lim idle cycles.
// The table read address is driven from the next-index logic so the entry
// for the following beat is already registered when a beat is accepted.
module axis_mvm_sequencer
    import mvm_seq_pkg::*;
#(
    parameter int DATAW = 512,
    parameter int USERW = 75,
    parameter int DESTW = 12,
    parameter int CMDD  = 64,
    parameter int TOW   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_wr_en,
    input  logic [$clog2(CMDD)-1:0]   cmd_wr_addr,
    input  logic [DATAW-1:0]          cmd_wr_data,
    input  logic [USERW-1:0]          cmd_wr_user,
    input  logic [DESTW-1:0]          cmd_wr_dest,
    input  logic                      start,
    input  logic [$clog2(CMDD):0]     num_cmds,
    input  logic [15:0]               exp_rsp,
    input  logic [TOW-1:0]            timeout_lim,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [15:0]               rsp_count,
    output logic [DATAW-1:0]          rsp_data,
    output logic [USERW-1:0]          rsp_user,
    output logic                      axis_tx_tvalid,
    output logic [DATAW-1:0]          axis_tx_tdata,
    output logic [DESTW-1:0]          axis_tx_tdest,
    output logic [USERW-1:0]          axis_tx_tuser,
    output logic                      axis_tx_tlast,
    input  logic                      axis_tx_tready,
    input  logic                      axis_rx_tvalid,
    input  logic [DATAW-1:0]          axis_rx_tdata,
    input  logic [USERW-1:0]          axis_rx_tuser,
    input  logic                      axis_rx_tlast,
    output logic                      axis_rx_tready
);

    localparam int CMDW = $clog2(CMDD);
    localparam int ENTW = DATAW + USERW + DESTW;
    localparam logic [CMDW:0] IDX_ONE = {{CMDW{1'b0}}, 1'b1};

    seq_state_e       state_r, state_nx_s;
    logic [CMDW:0]    idx_r, idx_nx_s, num_r;
    logic [15:0]      exp_r, rsp_count_r;
    logic [DATAW-1:0] rsp_data_r;
    logic [USERW-1:0] rsp_user_r;
    logic             tx_valid_r, busy_r, done_r, error_r;
    logic             idle_s, start_acc_s, rsp_acc_s, timeout_s;
    logic             ram_wr_en_s;
    logic [ENTW-1:0]  ram_rd_data_s;
    logic             unused_s;

    assign idle_s      = (state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR);
    assign start_acc_s = start && idle_s;
    assign rsp_acc_s   = axis_rx_tvalid && ((state_r == ST_ISSUE) || (state_r == ST_WAIT_RSP));
    assign ram_wr_en_s = cmd_wr_en && !busy_r;

`ifdef MVM_SEQ_TIMEOUT_EN
    logic [TOW-1:0] to_cnt_r, to_lim_r;

    // Count silent cycles in WAIT_RSP; any response or leaving the state restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_r <= '0;
        end else if ((state_r == ST_WAIT_RSP) && !rsp_acc_s) begin
            to_cnt_r <= to_cnt_r + {{(TOW-1){1'b0}}, 1'b1};
        end else begin
            to_cnt_r <= '0;
        end
    end

    // Timeout limit captured at an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_lim_r <= '0;
        end else if (start_acc_s) begin
            to_lim_r <= timeout_lim;
        end else begin
            to_lim_r <= to_lim_r;
        end
    end

    assign timeout_s = (to_lim_r != '0) && !rsp_acc_s &&
                       (({1'b0, to_cnt_r} + {{TOW{1'b0}}, 1'b1}) >= {1'b0, to_lim_r});
    assign unused_s  = axis_rx_tlast;
`else
    assign timeout_s = 1'b0;
    assign unused_s  = ^{axis_rx_tlast, timeout_lim};
`endif

    // Next state and next beat index
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = '0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_acc_s) begin
                    if (num_cmds != '0) begin
                        state_nx_s = ST_ISSUE;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_ISSUE: begin
                if (tx_valid_r && axis_tx_tready) begin
                    if (idx_r == (num_r - IDX_ONE)) begin
                        state_nx_s = ST_WAIT_RSP;
                        idx_nx_s   = '0;
                    end else begin
                        idx_nx_s   = idx_r + IDX_ONE;
                    end
                end else begin
                    idx_nx_s = idx_r;
                end
            end
            ST_WAIT_RSP: begin
                if (rsp_count_r >= exp_r) begin
                    state_nx_s = ST_DONE;
                end else if (timeout_s) begin
                    state_nx_s = ST_ERR;
                end else begin
                    state_nx_s = ST_WAIT_RSP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, beat index, tx valid and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            idx_r      <= idx_nx_s;
            tx_valid_r <= (state_nx_s == ST_ISSUE);
            busy_r     <= (state_nx_s == ST_ISSUE) || (state_nx_s == ST_WAIT_RSP);
            done_r     <= (state_nx_s == ST_DONE);
            error_r    <= (state_nx_s == ST_ERR);
        end
    end

    // Run length and expected response count captured at an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_r <= '0;
            exp_r <= '0;
        end else if (start_acc_s) begin
            num_r <= num_cmds;
            exp_r <= exp_rsp;
        end else begin
            num_r <= num_r;
            exp_r <= exp_r;
        end
    end

    // Response capture: saturating count plus last response payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_count_r <= '0;
            rsp_data_r  <= '0;
            rsp_user_r  <= '0;
        end else if (start_acc_s) begin
            rsp_count_r <= '0;
        end else if (rsp_acc_s) begin
            if (rsp_count_r != 16'hFFFF) begin
                rsp_count_r <= rsp_count_r + 16'd1;
            end
            rsp_data_r <= axis_rx_tdata;
            rsp_user_r <= axis_rx_tuser;
        end
    end

    mvm_seq_cmd_ram #(
        .DEPTH (CMDD),
        .WIDTH (ENTW),
        .AW    (CMDW)
    ) u_cmd_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ram_wr_en_s),
        .wr_addr (cmd_wr_addr),
        .wr_data ({cmd_wr_dest, cmd_wr_user, cmd_wr_data}),
        .rd_addr (idx_nx_s[CMDW-1:0]),
        .rd_data (ram_rd_data_s)
    );

    assign axis_tx_tvalid = tx_valid_r;
    assign axis_tx_tlast  = tx_valid_r;
    assign axis_tx_tdata  = ram_rd_data_s[DATAW-1:0];
    assign axis_tx_tuser  = ram_rd_data_s[DATAW +: USERW];
    assign axis_tx_tdest  = ram_rd_data_s[DATAW+USERW +: DESTW];
    assign axis_rx_tready = 1'b1;
    assign busy           = busy_r;
    assign done           = done_r;
    assign error          = error_r;
    assign rsp_count      = rsp_count_r;
    assign rsp_data       = rsp_data_r;
    assign rsp_user       = rsp_user_r;

endmodule
